// File: rtl/m_cp0.sv
// m_cp0: coprocessor-0 exception/interrupt controller for the M stage.
// Holds SR/Cause/EPC, raises a same-cycle exception request that flushes
// the pipe, and serves mfc0 reads, mtc0 writes and eret.
//
// Handshake note: there is no valid/ready pairing here. req is a
// combinational, single-cycle strobe; the pipeline must act on it in the
// same cycle it is high. en and exl_clr are plain qualifiers sampled at the
// clock edge, and both are ignored whenever req is high.
module m_cp0 #(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] PRID       = 32'h2022_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_in,
  output logic [31:0] cp0_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out,
  output logic [31:0] handler_pc
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // SR fields
  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  // Cause fields
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // Request decode: interrupts need IE and a matching unmasked line;
  // neither source is accepted while EXL is set.
  always_comb begin
    int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    exc_req = (exc_code_in != 5'd0) & ~exl_q;
    req     = int_req | exc_req;
  end

  // Next-state for all CP0 fields; a taken request blocks mtc0 and eret.
  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = hw_int;
    if (req) begin
      exl_d      = 1'b1;
      bd_d       = bd_in;
      exc_code_d = int_req ? 5'd0 : exc_code_in;
      epc_d      = (bd_in ? (vpc - 32'd4) : vpc) & 32'hffff_fffc;
    end else begin
      if (en && (cp0_addr == ADDR_SR)) begin
        im_d  = cp0_in[15:10];
        exl_d = cp0_in[1];
        ie_d  = cp0_in[0];
      end
      if (en && (cp0_addr == ADDR_EPC)) begin
        epc_d = cp0_in & 32'hffff_fffc;
      end
      // eret clears EXL even if the same cycle writes SR
      if (exl_clr) begin
        exl_d = 1'b0;
      end
    end
  end

  // Register update with synchronous reset dominating everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  // mfc0 read mux over the architectural register images.
  always_comb begin
    sr_word    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    cause_word = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'd0};
    case (cp0_addr)
      ADDR_SR:    cp0_out = sr_word;
      ADDR_CAUSE: cp0_out = cause_word;
      ADDR_EPC:   cp0_out = epc_q;
      ADDR_PRID:  cp0_out = PRID;
      default:    cp0_out = 32'd0;
    endcase
  end

  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_PC;

endmodule

// File: doc/m_cp0.md
Name: m_cp0

Overview:
- Coprocessor-0 exception/interrupt controller in the M stage.
- Consumes the per-instruction exception code merged from the M-stage checkers: load-address fault AdEL=4, store fault AdES=5, and codes carried down the pipe (RI=10, Ov=12, Syscall=8).
- Consumes the 6 hardware interrupt lines from Timer0, Timer1 and the interrupt generator.
- Holds SR/Cause/EPC, raises a one-cycle exception request that flushes the pipe, and serves mfc0/mtc0/eret.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception handler entry address driven on handler_pc.
- PRID, 32'h2022_0001, read-only value of register 15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  mtc0 write enable (M stage).
- cp0_addr  in  5  register select for mfc0/mtc0: 12 SR, 13 Cause, 14 EPC, 15 PRId.
- cp0_in  in  32  mtc0 write data.
- cp0_out  out  32  mfc0 read data (combinational).
- vpc  in  32  PC of the current M-stage instruction.
- bd_in  in  1  M-stage instruction sits in a delay slot.
- exc_code_in  in  5  merged exception code; 0 = none.
- hw_int  in  6  hardware interrupt lines: bit0 Timer0, bit1 Timer1, bit2 interrupt generator, bits 3–5 spare.
- exl_clr  in  1  eret in M stage.
- req  out  1  take exception/interrupt now (combinational).
- epc_out  out  32  current EPC, used as the eret target.
- handler_pc  out  32  constant HANDLER_PC.

Behaviour:
- Register fields:
  - SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0.
  - Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0.
  - EPC: 32 bits, [1:0] forced 0.
- Reset: SR=0, Cause=0, EPC=0. Outputs after reset: req=0, epc_out=0, cp0_out=0 for addr 12/13/14.
- Interrupt condition: int_req = |(hw_int & IM) & IE & !EXL.
- Exception condition: exc_req = (exc_code_in != 0) & !EXL.
- req = int_req | exc_req. Zero-latency, same cycle.
- Priority: interrupt over exception.
  - On int_req: ExcCode <= 0.
  - Otherwise: ExcCode <= exc_code_in.
- On req, at the next clock edge:
  - EXL <= 1.
  - BD <= bd_in.
  - EPC <= bd_in ? {vpc-4}[31:2],2'b0 : vpc[31:2],2'b0.
- IP <= hw_int every cycle, independent of req and EXL; it is not writable by mtc0.
- mtc0 (en=1, no req):
  - addr 12: SR <= cp0_in masked to IM/EXL/IE.
  - addr 14: EPC <= cp0_in[31:2],2'b0.
  - addr 13/15 or any other address: no effect.
- en is ignored when req=1; the faulting/interrupted mtc0 does not commit.
- exl_clr (no req): EXL <= 0 next edge. exl_clr with req=1: req wins, EXL stays/becomes 1.
- mtc0 SR and exl_clr in the same cycle: exl_clr wins for the EXL bit; the mtc0 value is taken for the other SR fields.
- cp0_out: combinational mux on cp0_addr; 15 returns PRID; unmapped addresses return 0. It reflects pre-edge values, so a read in the same cycle as a write returns the old value.
- While EXL=1: no nested exceptions or interrupts are accepted; Cause.ExcCode/BD and EPC hold.
- epc_out always equals the EPC register. Updates are visible the cycle after the req edge.
- Reset asserted mid-operation (e.g. same cycle as req): reset dominates; all registers go to 0.

Test Plan:
- Reset, then read addr 12/13/14/15 -> 0, 0, 0, 32'h2022_0001; req=0.
- exc_code_in=4 (AdEL), vpc=32'h3008, bd_in=0, EXL=0 -> req=1 same cycle; next cycle EPC=32'h3008, ExcCode=4, BD=0, EXL=1.
- mtc0 SR=32'h0000_0401 (IM bit0, IE), then hw_int=6'b000001 with exc_code_in=10 and vpc=32'h3100 in a delay slot -> req=1; ExcCode=0, BD=1, EPC=32'h30fc.
- With EXL=1, exc_code_in=5 and hw_int=6'h3f -> req=0; EPC/ExcCode unchanged; IP=6'h3f visible in Cause.
- exl_clr=1 with hw_int=0 -> EXL=0 next cycle; then exl_clr=1 together with exc_code_in=12 -> EXL stays 1, ExcCode=12.
- mtc0 EPC with 32'h3007 -> epc_out=32'h3004; mtc0 SR with en=1 during req=1 -> SR unchanged except EXL=1.
